// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-port ALU request arbiter: ALU opcodes,
// FSM state encoding and the opcode-to-occupancy latency helper.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 6;

  // ALU control codes
  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_SUB    = 6'b000001;
  localparam logic [5:0] OP_MUL    = 6'b000010;
  localparam logic [5:0] OP_DIV    = 6'b000011;
  localparam logic [5:0] OP_MOD    = 6'b000100;
  localparam logic [5:0] OP_NEG    = 6'b000101;
  localparam logic [5:0] OP_INC    = 6'b000110;
  localparam logic [5:0] OP_DEC    = 6'b000111;
  localparam logic [5:0] OP_AND    = 6'b010000;
  localparam logic [5:0] OP_OR     = 6'b010001;
  localparam logic [5:0] OP_XOR    = 6'b010010;
  localparam logic [5:0] OP_SLL    = 6'b100000;
  localparam logic [5:0] OP_SRL    = 6'b100001;
  localparam logic [5:0] OP_SRA    = 6'b100010;
  localparam logic [5:0] OP_BITSEL = 6'b110100;
  localparam logic [5:0] OP_RANDOM = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_state_e;

  // Number of cycles the ALU is held for a given control code. A zero
  // latency parameter is promoted to 1 so the countdown can never wrap.
  function automatic logic [7:0] op_latency(input logic [5:0] ctrl,
                                            input logic [7:0] mul_lat,
                                            input logic [7:0] div_lat);
    logic [7:0] lat;
    case (ctrl)
      OP_MUL:         lat = mul_lat;
      OP_DIV, OP_MOD: lat = div_lat;
      default:        lat = 8'd1;
    endcase
    if (lat == 8'd0) begin
      lat = 8'd1;
    end else begin
      lat = lat;
    end
    return lat;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the two request ports, the ALU-side operand/result signals and
// the shared response channel. The arbiter uses the slave modport; the
// environment (requesters, ALU, response consumer) uses master.
interface alu_req_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [DATA_W-1:0] alu_operand_a;
  logic [DATA_W-1:0] alu_operand_b;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry_out;
  logic              alu_overflow;
  logic              alu_negative;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  alu_result, alu_carry_out, alu_overflow, alu_negative, alu_zero,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_operand_a, alu_operand_b, alu_control,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output alu_result, alu_carry_out, alu_overflow, alu_negative, alu_zero,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_operand_a, alu_operand_b, alu_control,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter_rr.sv
// Combinational two-way round-robin grant. A lone requester always wins;
// with both valid, the port that was not granted last time wins. The
// last-grant pointer is owned by the parent.
module alu_rr_arbiter2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant0_o,
  output logic grant1_o
);

  // Pick the winner from the valids and the last-grant pointer
  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (valid0_i && valid1_i) begin
      if (last_grant_i) begin
        grant0_o = 1'b1;
      end else begin
        grant1_o = 1'b1;
      end
    end else if (valid0_i) begin
      grant0_o = 1'b1;
    end else if (valid1_i) begin
      grant1_o = 1'b1;
    end else begin
      grant0_o = 1'b0;
      grant1_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-port arbiter in front of a single shared ALU. Accepts one request at a
// time (round-robin), registers its operands/control into the ALU, holds the
// ALU for an opcode-dependent number of cycles, then returns result and
// flags on one response channel tagged with the requester id.
// Optional build macro ALU_ARB_DIVZERO_TRAP_EN: a DIV/MOD with b==0 skips the
// ALU and answers next cycle with result 0, flags 0001 and rsp_err set.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave arb_if
);

  arb_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic              trap_q, trap_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;

  logic              grant0_s, grant1_s;
  logic              ready0_s, ready1_s;
  logic              accept_s;
  logic [DATA_W-1:0] sel_a_s, sel_b_s;
  logic [CTRL_W-1:0] sel_ctrl_s;
  logic              div_zero_s;

  alu_rr_arbiter2 u_rr (
    .valid0_i     (arb_if.req0_valid),
    .valid1_i     (arb_if.req1_valid),
    .last_grant_i (last_grant_q),
    .grant0_o     (grant0_s),
    .grant1_o     (grant1_s)
  );

  // Ready is only offered in IDLE; gating with rst_n keeps both readies low
  // while reset is asserted even if a requester is already valid.
  assign ready0_s   = rst_n & (state_q == ST_IDLE) & grant0_s;
  assign ready1_s   = rst_n & (state_q == ST_IDLE) & grant1_s;
  assign accept_s   = ready0_s | ready1_s;
  assign sel_a_s    = grant1_s ? arb_if.req1_a    : arb_if.req0_a;
  assign sel_b_s    = grant1_s ? arb_if.req1_b    : arb_if.req0_b;
  assign sel_ctrl_s = grant1_s ? arb_if.req1_ctrl : arb_if.req0_ctrl;

`ifdef ALU_ARB_DIVZERO_TRAP_EN
  assign div_zero_s = ((sel_ctrl_s[5:0] == OP_DIV) || (sel_ctrl_s[5:0] == OP_MOD)) &&
                      (sel_b_s == {DATA_W{1'b0}});
`else
  assign div_zero_s = 1'b0;
`endif

  // Next-state and datapath updates for the IDLE/BUSY/DONE sequence
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    trap_d       = trap_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          alu_a_d      = sel_a_s;
          alu_b_d      = sel_b_s;
          alu_ctrl_d   = sel_ctrl_s;
          id_d         = grant1_s;
          last_grant_d = grant1_s;
          trap_d       = div_zero_s;
          // A trapped divide answers on the very next edge.
          cnt_d        = div_zero_s ? 8'd1
                         : op_latency(sel_ctrl_s[5:0], 8'(MUL_LAT), 8'(DIV_LAT));
          state_d      = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 8'd1) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          if (trap_q) begin
            rsp_result_d = {DATA_W{1'b0}};
            rsp_flags_d  = 4'b0001;
            rsp_err_d    = 1'b1;
          end else begin
            rsp_result_d = arb_if.alu_result;
            rsp_flags_d  = {arb_if.alu_carry_out, arb_if.alu_overflow,
                            arb_if.alu_negative, arb_if.alu_zero};
            rsp_err_d    = 1'b0;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        if (rsp_valid_q && arb_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_grant resets to 1 so port 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      trap_q       <= 1'b0;
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      alu_ctrl_q   <= {CTRL_W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_flags_q  <= 4'b0000;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      trap_q       <= trap_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign arb_if.req0_ready    = ready0_s;
  assign arb_if.req1_ready    = ready1_s;
  assign arb_if.alu_operand_a = alu_a_q;
  assign arb_if.alu_operand_b = alu_b_q;
  assign arb_if.alu_control   = alu_ctrl_q;
  assign arb_if.rsp_valid     = rsp_valid_q;
  assign arb_if.rsp_id        = rsp_id_q;
  assign arb_if.rsp_result    = rsp_result_q;
  assign arb_if.rsp_flags     = rsp_flags_q;
  assign arb_if.rsp_err       = rsp_err_q;

endmodule
